// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one UART transmitter among PORTS requesters.
// Define UART_ARB_TIMEOUT_EN to build the stall timeout that force-releases a stuck owner.
module uart_tx_arbiter #(
  parameter int PORTS          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic [PORTS-1:0]            grant,
  output logic                        busy,
  output logic                        timeout_event
);

  localparam int IDXW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 2 || PORTS > 16) begin : gBadPorts
    $error("uart_tx_arbiter: PORTS must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  winIdx;
  logic [IDXW-1:0]  candSel;
  logic             winFound;
  logic             lastBeat;
  logic             beatXfer;
  logic             timeoutHit;

  // ptr_q is the last winner; while in XFER it is also the index of the current owner.
  always_comb begin
    winIdx   = ptr_q;
    winFound = 1'b0;
    candSel  = '0;
    for (int k = 1; k <= PORTS; k++) begin
      candSel = IDXW'((int'(ptr_q) + k) % PORTS);
      if (!winFound && input_axis_tvalid[candSel]) begin
        winFound = 1'b1;
        winIdx   = candSel;
      end
    end
  end

  always_comb begin
    output_axis_tdata = '0;
    lastBeat          = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (ptr_q == IDXW'(p)) begin
        output_axis_tdata = input_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        lastBeat          = input_axis_tlast[p];
      end
    end
    if (state_q != XFER) begin
      output_axis_tdata = '0;
    end
  end

  // tready depends only on the registered grant and the sink, never on any tvalid.
  assign busy               = (state_q == XFER);
  assign grant              = grant_q;
  assign input_axis_tready  = grant_q & {PORTS{output_axis_tready}};
  assign output_axis_tvalid = busy & input_axis_tvalid[ptr_q];
  assign beatXfer           = output_axis_tvalid & output_axis_tready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (winFound) begin
          state_d         = XFER;
          ptr_d           = winIdx;
          grant_d         = '0;
          grant_d[winIdx] = 1'b1;
        end
      end
      XFER: begin
        if ((beatXfer && lastBeat) || timeoutHit) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDXW'(PORTS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] stallCnt_q, stallCnt_d;
  logic        timeoutEvent_q;

  // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign timeoutHit    = busy && !beatXfer && ((stallCnt_q + 16'd1) == 16'(TIMEOUT_CYCLES));
  assign timeout_event = timeoutEvent_q;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (!busy || beatXfer) begin
      stallCnt_d = '0;
    end else begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q     <= '0;
      timeoutEvent_q <= 1'b0;
    end else begin
      stallCnt_q     <= stallCnt_d;
      timeoutEvent_q <= timeoutHit;
    end
  end
`else
  assign timeoutHit    = 1'b0;
  assign timeout_event = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed packets with a scoreboard of expected (port, byte) beats.
// Build with UART_ARB_TIMEOUT_EN to exercise the stall timeout (TIMEOUT_CYCLES = 8).
module tb_uart_tx_arbiter;
  localparam int PORTS  = 4;
  localparam int DW     = 8;
  localparam int BUDGET = 300;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int SINK_STALL = 6;
`else
  localparam int SINK_STALL = 20;
`endif

  typedef struct packed {
    logic [3:0] port;
    logic [7:0] data;
  } beat_t;

  logic              clk;
  logic              rst;
  logic [PORTS*DW-1:0] input_axis_tdata;
  logic [PORTS-1:0]  input_axis_tvalid;
  logic [PORTS-1:0]  input_axis_tready;
  logic [PORTS-1:0]  input_axis_tlast;
  logic [DW-1:0]     output_axis_tdata;
  logic              output_axis_tvalid;
  logic              output_axis_tready;
  logic [PORTS-1:0]  grant;
  logic              busy;
  logic              timeout_event;

  logic [DW-1:0] portData [PORTS];
  logic          portValid [PORTS];
  logic          portLast [PORTS];
  beat_t         expQ[$];
  int            checks;
  int            errors;
  bit            monitorOn;

  uart_tx_arbiter #(
    .PORTS(PORTS),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_axis_tdata(input_axis_tdata),
    .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tready(input_axis_tready),
    .input_axis_tlast(input_axis_tlast),
    .output_axis_tdata(output_axis_tdata),
    .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tready(output_axis_tready),
    .grant(grant),
    .busy(busy),
    .timeout_event(timeout_event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit reached, required self-termination");
    $fatal(1, "[TB] watchdog expired");
  end

  // Per-port driver state is packed onto the DUT's flat buses.
  always_comb begin
    input_axis_tdata  = '0;
    input_axis_tvalid = '0;
    input_axis_tlast  = '0;
    for (int p = 0; p < PORTS; p++) begin
      input_axis_tdata[p*DW +: DW] = portData[p];
      input_axis_tvalid[p]         = portValid[p];
      input_axis_tlast[p]          = portLast[p];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectPacket(input int port, input int n, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = 4'(port);
      b.data = base + 8'(i);
      expQ.push_back(b);
    end
  endtask

  // Waits for the port's tready at a negedge, then returns just after the accepting edge.
  task automatic waitAccept(input int port);
    logic [1:0] pi;
    bit         ok;
    int         n;
    pi = 2'(port);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < BUDGET) begin
      @(negedge clk);
      if (input_axis_tready[pi]) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept wait port %0d: got no tready in %0d cycles, required tready", port, BUDGET);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input int n, input logic [7:0] base);
    logic [1:0] pi;
    pi = 2'(port);
    for (int i = 0; i < n; i++) begin
      portValid[pi] = 1'b1;
      portData[pi]  = base + 8'(i);
      portLast[pi]  = (i == n - 1);
      waitAccept(port);
    end
    portValid[pi] = 1'b0;
    portLast[pi]  = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic monitor();
    beat_t got;
    beat_t exp;
    forever begin
      @(negedge clk);
      if (monitorOn && output_axis_tvalid && output_axis_tready) begin
        got.port = 4'hF;
        for (int p = 0; p < PORTS; p++) begin
          if (grant[p]) got.port = 4'(p);
        end
        got.data = output_axis_tdata;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected beat: got port %0d data %0h, required no beat", got.port, got.data);
        end else begin
          exp = expQ.pop_front();
          checkOutput("beat port", 32'(got.port), 32'(exp.port));
          checkOutput("beat data", 32'(got.data), 32'(exp.data));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    monitorOn = 1'b0;
    rst = 1'b1;
    output_axis_tready = 1'b1;
    for (int p = 0; p < PORTS; p++) begin
      portValid[p] = 1'b0;
      portData[p]  = '0;
      portLast[p]  = 1'b0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    monitorOn = 1'b1;
    @(negedge clk);
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset tready", 32'(input_axis_tready), 32'h0);
    checkOutput("reset out tvalid", 32'(output_axis_tvalid), 32'h0);
    checkOutput("reset timeout_event", 32'(timeout_event), 32'h0);
    @(posedge clk);
    #1;

    // Test 1: single 3-beat packet from port 0.
    expectPacket(0, 3, 8'h41);
    fork
      applyStimulus(0, 3, 8'h41);
      begin
        @(negedge clk);
        checkOutput("t1 grant before arbitration", 32'(grant), 32'h0);
        checkOutput("t1 tready before arbitration", 32'(input_axis_tready), 32'h0);
        @(negedge clk);
        checkOutput("t1 grant", 32'(grant), 32'h1);
        checkOutput("t1 busy", 32'(busy), 32'h1);
      end
    join
    @(negedge clk);
    checkOutput("t1 grant after last", 32'(grant), 32'h0);
    checkOutput("t1 busy after last", 32'(busy), 32'h0);
    @(posedge clk);
    #1;

    // Test 2: all ports requesting; expected order 0,1,2,3,0 including the 3->0 wrap.
    applyReset();
    expectPacket(0, 2, 8'h01);
    expectPacket(1, 2, 8'h11);
    expectPacket(2, 2, 8'h21);
    expectPacket(3, 2, 8'h31);
    expectPacket(0, 2, 8'h05);
    fork
      begin
        applyStimulus(0, 2, 8'h01);
        applyStimulus(0, 2, 8'h05);
      end
      applyStimulus(1, 2, 8'h11);
      applyStimulus(2, 2, 8'h21);
      applyStimulus(3, 2, 8'h31);
    join

    // Test 3: ports 1 and 3 arrive while port 2 owns the UART; port 3 goes next.
    expectPacket(2, 3, 8'h61);
    expectPacket(3, 1, 8'h71);
    expectPacket(1, 1, 8'h51);
    fork
      applyStimulus(2, 3, 8'h61);
      begin
        repeat (2) @(posedge clk);
        #1;
        fork
          applyStimulus(3, 1, 8'h71);
          applyStimulus(1, 1, 8'h51);
        join
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          checkOutput("t3 grant locked", 32'(grant), 32'h4);
          checkOutput("t3 tready1 blocked", 32'(input_axis_tready[1]), 32'h0);
          checkOutput("t3 tready3 blocked", 32'(input_axis_tready[3]), 32'h0);
        end
      end
    join

    // Test 4: sink backpressure in the middle of a packet.
    expectPacket(1, 3, 8'h81);
    fork
      applyStimulus(1, 3, 8'h81);
      begin
        repeat (2) @(posedge clk);
        #1;
        output_axis_tready = 1'b0;
        repeat (SINK_STALL) begin
          @(negedge clk);
          checkOutput("t4 tdata held", 32'(output_axis_tdata), 32'h82);
          checkOutput("t4 out tvalid", 32'(output_axis_tvalid), 32'h1);
          checkOutput("t4 tready1 low", 32'(input_axis_tready[1]), 32'h0);
          checkOutput("t4 grant held", 32'(grant), 32'h2);
        end
        @(posedge clk);
        #1;
        output_axis_tready = 1'b1;
      end
    join

    // Test 5: reset during beat 2 abandons the packet and restores port 0 priority.
    expectPacket(2, 2, 8'h91);
    portValid[2] = 1'b1;
    portData[2]  = 8'h91;
    portLast[2]  = 1'b0;
    waitAccept(2);
    portData[2] = 8'h92;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    portValid[2] = 1'b0;
    expectPacket(0, 1, 8'hA1);
    expectPacket(3, 1, 8'hB1);
    fork
      applyStimulus(0, 1, 8'hA1);
      applyStimulus(3, 1, 8'hB1);
      begin
        @(negedge clk);
        checkOutput("t5 grant after reset", 32'(grant), 32'h0);
        checkOutput("t5 busy after reset", 32'(busy), 32'h0);
        checkOutput("t5 tready after reset", 32'(input_axis_tready), 32'h0);
        checkOutput("t5 out tvalid after reset", 32'(output_axis_tvalid), 32'h0);
      end
    join

    // Test 6: owner (port 1) drops tvalid mid-packet while port 2 waits.
    expectPacket(1, 1, 8'hC1);
    portValid[1] = 1'b1;
    portData[1]  = 8'hC1;
    portLast[1]  = 1'b0;
    waitAccept(1);
    portValid[1] = 1'b0;
    portValid[2] = 1'b1;
    portData[2]  = 8'hD1;
    portLast[2]  = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    expectPacket(2, 1, 8'hD1);
    repeat (8) begin
      @(negedge clk);
      checkOutput("t6 no early timeout", 32'(timeout_event), 32'h0);
      checkOutput("t6 grant held during stall", 32'(grant), 32'h2);
    end
    @(negedge clk);
    checkOutput("t6 timeout pulse", 32'(timeout_event), 32'h1);
    checkOutput("t6 grant released", 32'(grant), 32'h0);
    @(negedge clk);
    checkOutput("t6 port2 granted", 32'(grant), 32'h4);
    checkOutput("t6 pulse one cycle", 32'(timeout_event), 32'h0);
    @(posedge clk);
    #1;
    portValid[2] = 1'b0;
    portLast[2]  = 1'b0;
`else
    repeat (12) begin
      @(negedge clk);
      checkOutput("t6 grant held by stalled owner", 32'(grant), 32'h2);
      checkOutput("t6 timeout_event tied low", 32'(timeout_event), 32'h0);
      checkOutput("t6 tready2 blocked", 32'(input_axis_tready[2]), 32'h0);
      checkOutput("t6 out tvalid idle", 32'(output_axis_tvalid), 32'h0);
    end
    expectPacket(1, 1, 8'hC2);
    expectPacket(2, 1, 8'hD1);
    @(posedge clk);
    #1;
    portValid[1] = 1'b1;
    portData[1]  = 8'hC2;
    portLast[1]  = 1'b1;
    waitAccept(1);
    portValid[1] = 1'b0;
    portLast[1]  = 1'b0;
    waitAccept(2);
    portValid[2] = 1'b0;
    portLast[2]  = 1'b0;
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
